// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: pops A, B, opcode frames from a UART RX FIFO, drives an external ALU, pushes the result byte to TX.
// Optional inter-byte timeout enabled by defining UART_ALU_BRIDGE_TIMEOUT_EN.
module uart_alu_bridge #(
  parameter int N_BIT       = 8,
  parameter int N_OP        = 6,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TO_BIT      = 26
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [N_BIT-1:0] w_data,
  output logic             wr_uart,
  output logic [N_BIT-1:0] alu_a,
  output logic [N_BIT-1:0] alu_b,
  output logic [N_OP-1:0]  alu_op,
  input  logic [N_BIT-1:0] alu_result,
  output logic             busy,
  output logic             timeout_err
);
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SEND} state_t;
  state_t           state_q, state_d;
  logic [N_BIT-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
  logic [N_OP-1:0]  alu_op_q, alu_op_d;
  logic             busy_q, to_fire;
`ifdef UART_ALU_BRIDGE_TIMEOUT_EN
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  logic              terr_q;
  assign to_fire = (state_q inside {S_B, S_OP}) && rx_empty && cnt_q == TO_BIT'(TIMEOUT_CYC - 1);
  // Counting only while waiting mid-frame makes every accept, S_A entry and exec/send phase clear it.
  assign cnt_d = ((state_q inside {S_B, S_OP}) && rx_empty && !to_fire) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= to_fire;
    end
  end
  assign timeout_err = terr_q;
`else
  localparam logic TO_OK = (64'd2 ** TO_BIT) > 64'(TIMEOUT_CYC);
  assign to_fire     = 1'b0;
  assign timeout_err = TO_OK & 1'b0;
`endif
  // Pop is gated by reset so a FIFO holding data sees no strobe while reset is held.
  assign rd_uart = RESET && !rx_empty && (state_q inside {S_A, S_B, S_OP});
  assign wr_uart = RESET && !tx_full && state_q == S_SEND;
  assign w_data  = result_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign busy    = busy_q;
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    case (state_q)
      S_A: if (!rx_empty) begin
        alu_a_d = r_data;
        state_d = S_B;
      end
      S_B: if (!rx_empty) begin
        alu_b_d = r_data;
        state_d = S_OP;
      end
      S_OP: if (!rx_empty) begin
        alu_op_d = r_data[N_OP-1:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
        state_d  = S_SEND;
      end
      S_SEND: state_d = tx_full ? S_SEND : S_A;
      default: state_d = S_A;
    endcase
    if (to_fire) state_d = S_A;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_A;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      busy_q   <= state_d != S_A;
    end
  end
endmodule

// File: tb/tb_uart_alu_bridge.sv
// tb_uart_alu_bridge: FIFO and ALU models around uart_alu_bridge, scoreboard of expected result bytes.
module tb_uart_alu_bridge;
  logic       CLK = 1'b0, RESET = 1'b0, rx_empty = 1'b1, tx_full = 1'b0;
  logic [7:0] r_data = 8'h00, w_data, alu_a, alu_b, alu_result;
  logic [5:0] alu_op;
  logic       rd_uart, wr_uart, busy, timeout_err;

  uart_alu_bridge #(.N_BIT(8), .N_OP(6), .TIMEOUT_CYC(16), .TO_BIT(26)) dut (
    .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  logic [7:0] rxq[$], expq[$];
  int errs = 0, checks = 0, cyc = 0, npop = 0, nwr = 0, nterr = 0, bad_pop = 0;
  int last_pop_cyc = 0, last_wr_cyc = 0;
  bit hold = 0, rnd = 0, chk_first = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic upd();
    rx_empty = (rxq.size() == 0) || hold;
    r_data   = rx_empty ? 8'($urandom) : rxq[0];
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    expq.push_back(alu_fn(a, b, op[5:0]));
    upd();
  endtask

  task automatic step();
    logic       was_rd;
    logic [7:0] e;
    @(negedge CLK);
    if (rd_uart) begin
      npop++;
      last_pop_cyc = cyc;
      if (rx_empty) bad_pop++;
    end
    if (wr_uart) begin
      nwr++;
      last_wr_cyc = cyc;
      if (expq.size() == 0) chk("spurious_wr", 1, 0);
      else begin
        e = expq.pop_front();
        chk("w_data", w_data, e);
      end
    end
    if (timeout_err) nterr++;
    if (chk_first) begin
      chk("pop_after_rst", rd_uart, 1);
      chk_first = 0;
    end
    was_rd = rd_uart;
    @(posedge CLK);
    #1;
    cyc++;
    if (was_rd && rxq.size() > 0) void'(rxq.pop_front());
    if (rnd) begin
      tx_full = ($urandom % 3) == 0;
      hold    = ($urandom % 4) == 0;
    end
    upd();
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (rxq.size() == 0 && expq.size() == 0 && !busy) return;
      step();
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_popped(input int max);
    for (int i = 0; i < max; i++) begin
      if (rxq.size() == 0) return;
      step();
    end
    chk("pop_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, t0, c0;
    logic [7:0] ops[6] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
    logic [7:0] a, b, o;
    // Reset held with data waiting: no pop, everything cleared.
    send_frame(8'h55, 8'h11, 8'h20);
    #23;
    chk("rst_rd", rd_uart, 0);
    chk("rst_wr", wr_uart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_abop", {alu_a, alu_b, 2'b00, alu_op}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    chk_first = 1;
    wait_idle(40);

    // Basic frame and latency.
    p0 = npop; w0 = nwr;
    send_frame(8'h0F, 8'h03, 8'h20);
    wait_idle(40);
    chk("basic_pops", npop - p0, 3);
    chk("basic_wr", nwr - w0, 1);
    chk("basic_lat", last_wr_cyc - last_pop_cyc, 2);
    chk("basic_a", alu_a, 8'h0F);
    chk("basic_b", alu_b, 8'h03);
    chk("basic_op", alu_op, 6'h20);

    // Gapped bytes.
    expq.push_back(alu_fn(8'h30, 8'h05, 6'h22));
    for (int i = 0; i < 3; i++) begin
      rxq.push_back(i == 0 ? 8'h30 : i == 1 ? 8'h05 : 8'h22);
      upd();
      wait_popped(5);
      if (i < 2) begin
        p0 = npop;
        repeat (10) step();
        chk("gap_no_pop", npop - p0, 0);
        chk("gap_busy", busy, 1);
      end
    end
    wait_idle(40);

    // TX backpressure with two more frames queued.
    tx_full = 1'b1;
    p0 = npop; w0 = nwr;
    send_frame(8'h3C, 8'h0F, 8'h24);
    send_frame(8'h12, 8'h34, 8'h26);
    send_frame(8'h80, 8'h01, 8'h27);
    repeat (20) step();
    chk("bp_no_wr", nwr - w0, 0);
    chk("bp_pops", npop - p0, 3);
    tx_full = 1'b0;
    step();
    chk("bp_one_wr", nwr - w0, 1);
    wait_idle(60);
    chk("bp_total_wr", nwr - w0, 3);

    // Back-to-back frames.
    c0 = cyc; w0 = nwr;
    send_frame(8'hFF, 8'h01, 8'h22);
    send_frame(8'hAA, 8'h55, 8'h25);
    wait_idle(40);
    chk("b2b_wr", nwr - w0, 2);
    chk("b2b_cycles", last_wr_cyc - c0, 9);

    // Partial frame then silence.
    rxq.push_back(8'h01);
    upd();
    wait_popped(5);
    t0 = nterr;
    repeat (20) step();
`ifdef UART_ALU_BRIDGE_TIMEOUT_EN
    chk("to_pulse", nterr - t0, 1);
    chk("to_busy", busy, 0);
    chk("to_keep_a", alu_a, 8'h01);
`else
    chk("to_pulse", nterr - t0, 0);
    chk("to_busy", busy, 1);
    RESET = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
`endif
    send_frame(8'h07, 8'h08, 8'h20);
    wait_idle(40);
    chk("fresh_a", alu_a, 8'h07);

    // Randomized frames with random RX holds and TX backpressure.
    rnd = 1;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      o = {2'($urandom), ops[$urandom % 6][5:0]};
      send_frame(a, b, o);
    end
    wait_idle(3000);
    rnd = 0; tx_full = 1'b0; hold = 0;
    upd();
    chk("rand_drained", expq.size(), 0);
    chk("pop_when_empty", bad_pop, 0);
`ifdef UART_ALU_BRIDGE_TIMEOUT_EN
    chk("terr_total", nterr, 1);
`else
    chk("terr_total", nterr, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
